// File: rtl/serial_word_loader_if.sv
// Serial-in / parallel-out bundle between a bit source, the word loader and the downstream PIPO stage.
interface serial_word_loader_if #(
    parameter int REGISTER_WIDTH = 16
);
    logic                      i_start;
    logic                      i_valid;
    logic                      i_bit;
    logic [REGISTER_WIDTH-1:0] o_data;
    logic                      o_we;
    logic                      o_busy;
    logic                      o_err;

    modport master (
        output i_start, i_valid, i_bit,
        input  o_data, o_we, o_busy, o_err
    );

    modport slave (
        input  i_start, i_valid, i_bit,
        output o_data, o_we, o_busy, o_err
    );
endinterface

// File: rtl/serial_word_loader.sv
// Assembles an MSB-first serial frame into a word, with an optional trailing even-parity bit,
// and hands good words to the downstream PIPO stage through a one-cycle write strobe.
module serial_word_loader #(
    parameter int REGISTER_WIDTH = 16,
    parameter bit PARITY_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_word_loader_if.slave  bus
);
    localparam int              CW       = $clog2(REGISTER_WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(REGISTER_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_PAR   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t                    state_q;
    logic [REGISTER_WIDTH-1:0] shreg_q;
    logic [REGISTER_WIDTH-1:0] data_q;
    logic [CW-1:0]             count_q;
    logic                      we_q;
    logic                      err_q;
    logic                      busy_q;
    logic [REGISTER_WIDTH-1:0] shift_s;

    function automatic logic even_parity_ok(input logic [REGISTER_WIDTH-1:0] word, input logic p);
        return ~(^word ^ p);
    endfunction

    assign shift_s = {shreg_q[REGISTER_WIDTH-2:0], bus.i_bit};

    // Frame FSM; strobes and data are set on the edge that enters DONE/ERR so they show in that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            if (bus.i_start) begin
                // A start in any state begins a fresh frame and drops whatever was collected.
                state_q <= ST_SHIFT;
                shreg_q <= '0;
                count_q <= '0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (bus.i_valid) begin
                            shreg_q <= shift_s;
                            if (count_q == LAST_BIT) begin
                                count_q <= '0;
                                if (PARITY_EN) begin
                                    state_q <= ST_PAR;
                                end else begin
                                    state_q <= ST_DONE;
                                    busy_q  <= 1'b0;
                                    we_q    <= 1'b1;
                                    data_q  <= shift_s;
                                end
                            end else begin
                                count_q <= count_q + CW'(1);
                            end
                        end
                    end
                    ST_PAR: begin
                        if (bus.i_valid) begin
                            busy_q <= 1'b0;
                            if (even_parity_ok(shreg_q, bus.i_bit)) begin
                                state_q <= ST_DONE;
                                we_q    <= 1'b1;
                                data_q  <= shreg_q;
                            end else begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_data = data_q;
    assign bus.o_we   = we_q;
    assign bus.o_err  = err_q;
    assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_serial_word_loader.sv
// Drives one loader without parity and one with parity from the same random serial stream,
// comparing both against a bit-counting frame model every cycle.
module tb_serial_word_loader;
    logic clk;
    logic rst;

    serial_word_loader_if #(.REGISTER_WIDTH(16)) if0 ();
    serial_word_loader_if #(.REGISTER_WIDTH(16)) if1 ();

    serial_word_loader #(.REGISTER_WIDTH(16), .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_word_loader #(.REGISTER_WIDTH(16), .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame model: collected bit count, running word value and count of ones per instance.
    bit          m_act  [2];
    int          m_n    [2];
    int          m_word [2];
    int          m_ones [2];
    logic [15:0] m_data [2];
    logic        m_we   [2];
    logic        m_err  [2];

    int          we_cnt [2];
    int          err_cnt[2];
    logic [15:0] first_we_data[2];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            m_act[p]  = 1'b0;
            m_n[p]    = 0;
            m_word[p] = 0;
            m_ones[p] = 0;
            m_data[p] = 16'h0000;
            m_we[p]   = 1'b0;
            m_err[p]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input int p, input logic s, input logic v, input logic b);
        m_we[p]  = 1'b0;
        m_err[p] = 1'b0;
        if (s) begin
            m_act[p]  = 1'b1;
            m_n[p]    = 0;
            m_word[p] = 0;
            m_ones[p] = 0;
        end else if (m_act[p] && v) begin
            if (m_n[p] < 16) m_word[p] = m_word[p] * 2 + int'(b);
            m_ones[p] += int'(b);
            m_n[p]++;
            if (m_n[p] == 16 + p) begin
                m_act[p] = 1'b0;
                if (p == 0 || (m_ones[p] % 2) == 0) begin
                    m_we[p]   = 1'b1;
                    m_data[p] = m_word[p][15:0];
                end else begin
                    m_err[p] = 1'b1;
                end
            end
        end
    endfunction

    task automatic clear_counts();
        for (int p = 0; p < 2; p++) begin
            we_cnt[p]        = 0;
            err_cnt[p]       = 0;
            first_we_data[p] = 16'h0000;
        end
    endtask

    task automatic set_inputs(input logic s, input logic v, input logic b);
        if0.i_start = s; if0.i_valid = v; if0.i_bit = b;
        if1.i_start = s; if1.i_valid = v; if1.i_bit = b;
    endtask

    task automatic drive(input logic s, input logic v, input logic b);
        set_inputs(s, v, b);
        @(posedge clk);
        model_step(0, s, v, b);
        model_step(1, s, v, b);
        #1;
        check_eq("p0_we",   {31'd0, if0.o_we},   {31'd0, m_we[0]});
        check_eq("p0_err",  {31'd0, if0.o_err},  {31'd0, m_err[0]});
        check_eq("p0_busy", {31'd0, if0.o_busy}, {31'd0, m_act[0]});
        check_eq("p0_data", {16'd0, if0.o_data}, {16'd0, m_data[0]});
        check_eq("p1_we",   {31'd0, if1.o_we},   {31'd0, m_we[1]});
        check_eq("p1_err",  {31'd0, if1.o_err},  {31'd0, m_err[1]});
        check_eq("p1_busy", {31'd0, if1.o_busy}, {31'd0, m_act[1]});
        check_eq("p1_data", {16'd0, if1.o_data}, {16'd0, m_data[1]});
        if (if0.o_we) begin
            if (we_cnt[0] == 0) first_we_data[0] = if0.o_data;
            we_cnt[0]++;
        end
        if (if1.o_we) begin
            if (we_cnt[1] == 0) first_we_data[1] = if1.o_data;
            we_cnt[1]++;
        end
        if (if0.o_err) err_cnt[0]++;
        if (if1.o_err) err_cnt[1]++;
    endtask

    task automatic send_frame(input logic [15:0] word, input logic par, input bit gaps);
        drive(1'b1, 1'($urandom), 1'($urandom));
        for (int i = 15; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'($urandom));
            drive(1'b0, 1'b1, word[i]);
        end
        if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'($urandom));
        drive(1'b0, 1'b1, par);
    endtask

    function automatic logic par_of(input logic [15:0] w);
        return ^w;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_p0"}, {if0.o_we, if0.o_err, if0.o_busy, 13'd0, if0.o_data}, 32'd0);
        check_eq({tag, "_p1"}, {if1.o_we, if1.o_err, if1.o_busy, 13'd0, if1.o_data}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0);
        model_reset();
        clear_counts();

        // Reset held with random inputs, then released with no start.
        repeat (5) begin
            set_inputs(1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        set_inputs(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (6) drive(1'b0, 1'($urandom), 1'($urandom));
        check_zero("post_reset_idle");

        // Reset in the middle of an all-ones frame.
        clear_counts();
        drive(1'b1, 1'b0, 1'b0);
        repeat (8) drive(1'b0, 1'b1, 1'b1);
        check_eq("midframe_busy_before", {31'd0, if1.o_busy}, 32'd1);
        rst = 1'b0;
        #2;
        model_reset();
        check_zero("midframe_reset");
        #1;
        rst = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        check_eq("midframe_no_we", we_cnt[0] + we_cnt[1], 32'd0);
        send_frame(16'h0001, 1'b1, 1'b0);
        check_eq("fresh_0001_p0", {16'd0, if0.o_data}, 32'h0001);
        check_eq("fresh_0001_p1", {16'd0, if1.o_data}, 32'h0001);

        // No-parity loader: 0xA5C3.
        clear_counts();
        send_frame(16'hA5C3, par_of(16'hA5C3), 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("a5c3_data_p0", {16'd0, if0.o_data}, 32'hA5C3);
        check_eq("a5c3_we_cnt_p0", we_cnt[0], 32'd1);

        // Parity loader: 0x00FF with good then bad parity.
        clear_counts();
        send_frame(16'h00FF, 1'b0, 1'b0);
        check_eq("00ff_good_we_p1", we_cnt[1], 32'd1);
        check_eq("00ff_good_data_p1", {16'd0, if1.o_data}, 32'h00FF);
        clear_counts();
        send_frame(16'h00FF, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("00ff_bad_err_p1", err_cnt[1], 32'd1);
        check_eq("00ff_bad_we_p1", we_cnt[1], 32'd0);
        check_eq("00ff_bad_data_p1", {16'd0, if1.o_data}, 32'h00FF);

        // Gaps between bits.
        clear_counts();
        send_frame(16'h1234, par_of(16'h1234), 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("gaps_1234_p0", {16'd0, if0.o_data}, 32'h1234);
        check_eq("gaps_1234_p1", {16'd0, if1.o_data}, 32'h1234);

        // Restart after a partial frame.
        clear_counts();
        drive(1'b1, 1'b0, 1'b0);
        repeat (8) drive(1'b0, 1'b1, 1'($urandom));
        send_frame(16'hBEEF, par_of(16'hBEEF), 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("restart_we_cnt_p0", we_cnt[0], 32'd1);
        check_eq("restart_we_cnt_p1", we_cnt[1], 32'd1);
        check_eq("restart_err_cnt_p1", err_cnt[1], 32'd0);
        check_eq("restart_beef_p1", {16'd0, if1.o_data}, 32'hBEEF);

        // Back-to-back: next start lands in the parity loader's DONE cycle.
        clear_counts();
        send_frame(16'h1111, par_of(16'h1111), 1'b0);
        send_frame(16'h2222, par_of(16'h2222), 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("b2b_we_cnt_p1", we_cnt[1], 32'd2);
        check_eq("b2b_first_p1", {16'd0, first_we_data[1]}, 32'h1111);
        check_eq("b2b_second_p1", {16'd0, if1.o_data}, 32'h2222);
        check_eq("b2b_we_cnt_p0", we_cnt[0], 32'd2);

        // Random whole frames with random parity quality.
        repeat (40) begin
            logic [15:0] w;
            w = 16'($urandom);
            send_frame(w, par_of(w) ^ 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // Unstructured random stream with occasional starts.
        repeat (3000) drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
